// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce family of filters.
package debounce_pkg;

  // Default acceptance window, common to every debounce user in the design
  localparam int unsigned DEFAULT_STABLE_TICKS = 128;

  // Width of a counter that must hold values 0 .. ticks (never less than 1 bit)
  function automatic int unsigned cnt_width(input int unsigned ticks);
    int unsigned w;
    w = (ticks + 1 <= 2) ? 1 : $clog2(ticks + 1);
    return w;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchroniser, mismatch-duration counter,
// debounced level and one-cycle rise/fall pulses.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEFAULT_STABLE_TICKS,
  parameter logic        RESET_BIT    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_en,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic accept_c
);

  localparam int unsigned     CNT_W   = cnt_width(STABLE_TICKS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_TICKS - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_nxt;
  logic             rise_nxt;
  logic             fall_nxt;

  // Two-flop synchroniser; reset to the channel's idle value so no false edge appears
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= RESET_BIT;
      s2 <= RESET_BIT;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // Filter next-state: any agreement clears progress, a full window accepts the new value
  always_comb begin
    cnt_nxt   = cnt;
    level_nxt = level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    if (s2 == level) begin
      cnt_nxt = '0;
    end else if (tick_en) begin
      if (cnt == CNT_MAX) begin
        level_nxt = s2;
        cnt_nxt   = '0;
        rise_nxt  = s2;
        fall_nxt  = ~s2;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  assign accept_c = rise_nxt | fall_nxt;

  // Filter state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= RESET_BIT;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      level <= level_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debouncer: independent debounce_ch per input plus a shared
// change indicator aligned with the rise/fall pulses.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned          NUM_CH       = 4,
  parameter int unsigned          STABLE_TICKS = DEFAULT_STABLE_TICKS,
  parameter logic [NUM_CH-1:0]    RESET_VAL    = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_en,
  input  logic [NUM_CH-1:0] din,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic              any_change
);

  logic [NUM_CH-1:0] accept_c;

  // One filter per input; channels share only clock, reset and tick qualifier
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_ch #(
      .STABLE_TICKS (STABLE_TICKS),
      .RESET_BIT    (RESET_VAL[i])
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .tick_en  (tick_en),
      .din      (din[i]),
      .level    (level[i]),
      .rise     (rise[i]),
      .fall     (fall[i]),
      .accept_c (accept_c[i])
    );
  end

  // Registered from the channels' next-state pulses so it lands in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      any_change <= 1'b0;
    end else begin
      any_change <= |accept_c;
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank (2 channels, 4-tick window).
module tb_debounce_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_en;
  logic [1:0] din;
  logic [1:0] level, rise, fall;
  logic       any_change;
  logic [1:0] din2;
  logic [1:0] level2, rise2, fall2;
  logic       any2;

  int n_tests = 0;
  int n_fail  = 0;
  int n_p2    = 0;

  always #5 clk = ~clk;

  debounce_bank #(.NUM_CH(2), .STABLE_TICKS(4), .RESET_VAL(2'b00)) dut (
    .clk(clk), .reset(reset), .tick_en(tick_en), .din(din),
    .level(level), .rise(rise), .fall(fall), .any_change(any_change)
  );

  debounce_bank #(.NUM_CH(2), .STABLE_TICKS(4), .RESET_VAL(2'b10)) dut2 (
    .clk(clk), .reset(reset), .tick_en(1'b1), .din(din2),
    .level(level2), .rise(rise2), .fall(fall2), .any_change(any2)
  );

  typedef struct {
    logic [1:0] din;
    logic       te;
    logic [1:0] lvl;
    logic [1:0] rs;
    logic [1:0] fl;
    logic       any;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic [1:0] d, input logic te,
                     input logic [1:0] l, input logic [1:0] r,
                     input logic [1:0] f, input logic a);
    vec_t v;
    v.din = d; v.te = te; v.lvl = l; v.rs = r; v.fl = f; v.any = a;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pack_out(input logic [1:0] l, input logic [1:0] r,
                                  input logic [1:0] f, input logic a);
    return int'({l, r, f, a});
  endfunction

  // Any pulse from the RESET_VAL=10 instance is an error (its input never moves)
  always @(negedge clk) begin
    if (!reset && (rise2 != 2'b00 || fall2 != 2'b00 || any2)) n_p2++;
  end

  initial begin
    int seen;
    int pulses;

    reset = 1'b1; din = 2'b00; din2 = 2'b10; tick_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", pack_out(level, rise, fall, any_change), 0);
    chk("reset_val_10", pack_out(level2, rise2, fall2, any2), pack_out(2'b10, 2'b00, 2'b00, 1'b0));
    reset = 1'b0;

    // Clean step, release, bounce, falling accept, simultaneous rise
    add(5, 2'b01, 1, 2'b00, 2'b00, 2'b00, 0);
    add(1, 2'b01, 1, 2'b01, 2'b01, 2'b00, 1);
    add(1, 2'b01, 1, 2'b01, 2'b00, 2'b00, 0);
    add(5, 2'b00, 1, 2'b01, 2'b00, 2'b00, 0);
    add(1, 2'b00, 1, 2'b00, 2'b00, 2'b01, 1);
    add(1, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0);
    add(3, 2'b10, 1, 2'b00, 2'b00, 2'b00, 0);
    add(1, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0);
    add(5, 2'b10, 1, 2'b00, 2'b00, 2'b00, 0);
    add(1, 2'b10, 1, 2'b10, 2'b10, 2'b00, 1);
    add(4, 2'b10, 1, 2'b10, 2'b00, 2'b00, 0);
    add(5, 2'b00, 1, 2'b10, 2'b00, 2'b00, 0);
    add(1, 2'b00, 1, 2'b00, 2'b00, 2'b10, 1);
    add(1, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0);
    add(5, 2'b11, 1, 2'b00, 2'b00, 2'b00, 0);
    add(1, 2'b11, 1, 2'b11, 2'b11, 2'b00, 1);
    add(1, 2'b11, 1, 2'b11, 2'b00, 2'b00, 0);

    foreach (vecs[i]) begin
      din = vecs[i].din;
      tick_en = vecs[i].te;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), pack_out(level, rise, fall, any_change),
          pack_out(vecs[i].lvl, vecs[i].rs, vecs[i].fl, vecs[i].any));
    end

    // Reset mid-count: channel 1 is counting toward a fall when reset hits
    din = 2'b01;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", pack_out(level, rise, fall, any_change), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_reset_e%0d", e), pack_out(level, rise, fall, any_change), 0);
    end
    @(posedge clk);
    #1;
    chk("post_reset_e6", pack_out(level, rise, fall, any_change), pack_out(2'b01, 2'b01, 2'b00, 1'b1));

    // Prescaled: tick every 8th cycle, acceptance on the 4th tick
    reset = 1'b1;
    din = 2'b00;
    @(posedge clk);
    #1;
    reset = 1'b0;
    seen = 999;
    din = 2'b01;
    for (int c = 0; c < 100; c++) begin
      tick_en = ((c % 8) == 7);
      @(posedge clk);
      #1;
      if (level[0]) begin
        seen = c;
        chk("prescale_rise", pack_out(level, rise, fall, any_change), pack_out(2'b01, 2'b01, 2'b00, 1'b1));
        break;
      end
    end
    chk("prescale_latency", seen, 31);

    // 5-cycle low glitch between ticks must be ignored
    pulses = 0;
    for (int c = 32; c < 64; c++) begin
      tick_en = ((c % 8) == 7);
      din = (c >= 33 && c < 38) ? 2'b00 : 2'b01;
      @(posedge clk);
      #1;
      if (any_change || rise != 2'b00 || fall != 2'b00) pulses++;
    end
    chk("glitch_pulses", pulses, 0);
    chk("glitch_level", int'(level), 1);

    chk("reset_val_10_end", int'(level2), 2);
    chk("reset_val_10_pulses", n_p2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised, multi-channel successor to the single-button debouncer; filters NUM_CH asynchronous inputs (buttons, DIP switches, PS/2 strap lines) in one instance.
- Per channel: 2-flop synchroniser, mismatch-duration counter with programmable stable threshold, optional prescale tick, debounced level plus one-cycle rise/fall pulses.
- Sits between top-level pads and control logic; replaces per-pin debouncer instances.

Parameters:
- NUM_CH, 4, number of independent channels (>=1).
- STABLE_TICKS, 128, consecutive ticks a new value must persist before being accepted (>=1).
- RESET_VAL, {NUM_CH{1'b0}}, per-channel value of level after reset (NUM_CH bits).
- CNT_W, $clog2(STABLE_TICKS+1), counter width; derived, not for override.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tick_en  in  1  counter advance qualifier; tie 1 for per-clock counting, drive a prescaler strobe for long windows.
- din  in  NUM_CH  raw asynchronous inputs.
- level  out  NUM_CH  debounced value.
- rise  out  NUM_CH  one-cycle pulse when level goes 0->1.
- fall  out  NUM_CH  one-cycle pulse when level goes 1->0.
- any_change  out  1  OR of rise|fall, registered with them (same cycle).

Behaviour:
- Reset (async assert, any time incl. mid-count): s1, s2 <= RESET_VAL; cnt <= 0; level <= RESET_VAL; rise, fall, any_change <= 0. Synchronous release on clk.
- Synchroniser per channel: s1 <= din[i]; s2 <= s1. Only s2 feeds the filter.
- Filter per channel, evaluated every clk edge:
  - s2 == level[i]: cnt <= 0 (any bounce back clears progress, regardless of tick_en).
  - s2 != level[i], tick_en=0: cnt holds.
  - s2 != level[i], tick_en=1, cnt < STABLE_TICKS-1: cnt <= cnt+1.
  - s2 != level[i], tick_en=1, cnt == STABLE_TICKS-1: level[i] <= s2; cnt <= 0; rise[i] <= s2; fall[i] <= ~s2.
- rise/fall default 0 every cycle unless set by the accept condition; never both high on one channel; any_change = |(rise|fall) next-state, registered.
- Latency (tick_en=1): din step held steady from just before edge k -> level, rise/fall change on edge k+STABLE_TICKS+1, i.e. STABLE_TICKS+2 edges after the change. STABLE_TICKS=1 -> 3 edges.
- Latency with strobe tick_en: 2 sync edges, then STABLE_TICKS tick-qualified edges while mismatch persists.
- Glitch shorter than STABLE_TICKS ticks (after sync): no level change, no pulse, cnt returns to 0.
- Channels fully independent; simultaneous accepts on several channels all pulse in the same cycle.
- cnt never exceeds STABLE_TICKS-1; no wrap.
- din change equal to level while counting (bounce) clears cnt on the same edge s2 shows it.

Decomposition:
- Shared package debounce_pkg: function for counter width, default STABLE_TICKS constant (128) shared with existing debounce users.
- Natural sub-module: debounce_ch (one channel: synchroniser, counter, level/rise/fall, with per-instance RESET_VAL bit); debounce_bank is a generate loop plus any_change OR.

Test Plan (NUM_CH=2, STABLE_TICKS=4, RESET_VAL=2'b00, tick_en=1 unless stated):
- Reset mid-count: din[0]=1 for 3 cycles, pulse reset -> level=00, rise=fall=00, counter restarts; acceptance needs full 6 edges after release.
- Clean step: din[0] 0->1 before edge k, held -> level[0]=1 and rise[0]=1 exactly at edge k+5, rise[0]=0 at k+6, any_change=1 for that one cycle only.
- Bounce: din[1] high 3 cycles, low 1, high 10 -> no change during bounce; level[1]=1 at edge 6 after final rising edge; exactly one rise[1] pulse.
- Release: after level[0]=1, din[0]=0 held -> fall[0]=1 single cycle, level[0]=0, rise[0] stays 0.
- Prescaled: tick_en high 1 of every 8 cycles, din[0] step -> level[0] changes after 4 ticks (~32 cycles + sync); single glitch of 5 cycles between ticks -> no change.
- Simultaneous: both din bits 0->1 same cycle -> rise=11 in same cycle, any_change=1 one cycle; RESET_VAL=2'b10 variant -> level=10 after reset, no pulses.
